register_file: RTL and testbench

Eight-entry register file (four general registers R1–R4, four temporaries T1–T4) built from per-register clear/load/decrement/increment cells. It sits directly downstream of the single-register cell and is the storage stage that feeds the ALU operand inputs. A shared function select is applied to every register whose enable bit is set. Two independent combinational read ports expose any register to the datapath.

---
 rtl/register_file_pkg.sv | 25 ++
 rtl/register_file_rf_cell.sv | 39 +++
 rtl/register_file.sv | 43 ++++
 tb/tb_register_file.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared encodings for the register file: operation select and read-port select.
package register_file_pkg;

  localparam int NBITS_DEF = 16;
  localparam int NUM_REGS  = 8;

  // Operation applied to every enabled register
  typedef enum logic [1:0] {
    CLEAR = 2'b00,
    LOAD  = 2'b01,
    DEC   = 2'b10,
    INC   = 2'b11
  } funsel_e;

  // Read-port select: general registers first, temporaries after
  localparam logic [2:0] SEL_R1 = 3'd0;
  localparam logic [2:0] SEL_R2 = 3'd1;
  localparam logic [2:0] SEL_R3 = 3'd2;
  localparam logic [2:0] SEL_R4 = 3'd3;
  localparam logic [2:0] SEL_T1 = 3'd4;
  localparam logic [2:0] SEL_T2 = 3'd5;
  localparam logic [2:0] SEL_T3 = 3'd6;
  localparam logic [2:0] SEL_T4 = 3'd7;

endpackage

// File: rtl/register_file_rf_cell.sv
// One storage cell: clear / load / decrement / increment when enabled, else hold.
module rf_cell
  import register_file_pkg::*;
#(
  parameter int NBits = NBITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  funsel_e          funsel_i,
  input  logic [NBits-1:0] d_i,
  output logic [NBits-1:0] q_o
);

  logic [NBits-1:0] q_q, q_d;

  // Next value; arithmetic wraps naturally at NBits
  always_comb begin
    q_d = q_q;
    if (en_i) begin
      unique case (funsel_i)
        CLEAR:   q_d = '0;
        LOAD:    q_d = d_i;
        DEC:     q_d = q_q - NBits'(1);
        INC:     q_d = q_q + NBits'(1);
        default: q_d = q_q;
      endcase
    end
  end

  // State register, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/register_file.sv
// Eight-entry register file (R1-R4, T1-T4) with shared op select and two
// combinational read ports. Reads see pre-edge contents; there is no bypass.
module register_file
  import register_file_pkg::*;
#(
  parameter int NBits = NBITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NBits-1:0] i,
  input  logic [1:0]       funsel,
  input  logic [3:0]       rsel,
  input  logic [3:0]       tsel,
  input  logic [2:0]       outasel,
  input  logic [2:0]       outbsel,
  output logic [NBits-1:0] outa,
  output logic [NBits-1:0] outb
);

  // Index 0..3 = R1..R4, 4..7 = T1..T4, matching the read-select encoding
  logic [NUM_REGS-1:0]            en;
  logic [NUM_REGS-1:0][NBits-1:0] regs;

  assign en = {tsel, rsel};

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
    rf_cell #(.NBits(NBits)) u_cell (
      .clk      (clk),
      .rst      (rst),
      .en_i     (en[g]),
      .funsel_i (funsel_e'(funsel)),
      .d_i      (i),
      .q_o      (regs[g])
    );
  end

  // Two independent 8:1 read muxes
  always_comb begin
    outa = regs[outasel];
    outb = regs[outbsel];
  end

endmodule

// File: tb/tb_register_file.sv
// Directed bench with a behavioural model checked every negedge,
// plus literal expectations at the interesting points.
module tb_register_file;
  import register_file_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] i = '0;
  logic [1:0]  funsel = 2'b00;
  logic [3:0]  rsel = '0, tsel = '0;
  logic [2:0]  outasel = '0, outbsel = '0;
  logic [15:0] outa, outb;

  int ncmp = 0, nerr = 0;
  int mdl [8] = '{default: 0};

  register_file #(.NBits(16)) dut (
    .clk(clk), .rst(rst), .i(i), .funsel(funsel), .rsel(rsel), .tsel(tsel),
    .outasel(outasel), .outbsel(outbsel), .outa(outa), .outb(outb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each enabled register applies the op to its own old value, mod 65536
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) mdl[k] = 0;
    end else begin
      logic [7:0] e;
      int nxt [8];
      e = {tsel, rsel};
      for (int k = 0; k < 8; k++) begin
        nxt[k] = mdl[k];
        if (e[k]) begin
          case (funsel)
            2'b00: nxt[k] = 0;
            2'b01: nxt[k] = int'(i);
            2'b10: nxt[k] = (mdl[k] + 65535) % 65536;
            default: nxt[k] = (mdl[k] + 1) % 65536;
          endcase
        end
      end
      for (int k = 0; k < 8; k++) mdl[k] = nxt[k];
    end
  end

  // Continuous comparison of both read ports against the model
  always @(negedge clk) begin
    chk("porta_vs_model", outa, 16'(mdl[outasel]));
    chk("portb_vs_model", outb, 16'(mdl[outbsel]));
  end

  // One write cycle; leaves enables cleared afterwards
  task automatic wr(input logic [1:0] fs, input logic [15:0] d,
                    input logic [3:0] rs, input logic [3:0] ts);
    funsel = fs; i = d; rsel = rs; tsel = ts;
    @(posedge clk); #1;
    rsel = '0; tsel = '0;
  endtask

  task automatic rd(input string nm, input logic [2:0] s, input logic [15:0] exp);
    outasel = s; #1;
    chk(nm, outa, exp);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2 rd("reset_r1", SEL_R1, 16'h0000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Preload then async reset between edges
    wr(LOAD, 16'h1234, 4'b0001, 4'b0000);
    rd("preload_r1", SEL_R1, 16'h1234);
    #1 rst = 1'b1;
    rd("async_rst_r1", SEL_R1, 16'h0000);
    for (int s = 0; s < 8; s++) rd("rst_all", 3'(s), 16'h0000);
    @(posedge clk); #1 rst = 1'b0;

    // Load and read both ports
    wr(LOAD, 16'hBEEF, 4'b0001, 4'b0000);
    outasel = SEL_R1; outbsel = SEL_T1; #1;
    chk("load_a", outa, 16'hBEEF);
    chk("load_b", outb, 16'h0000);

    // Wrap-around on T2
    wr(CLEAR, 16'h0, 4'b0000, 4'b0010);
    wr(DEC, 16'h0, 4'b0000, 4'b0010);
    rd("wrap_dec", SEL_T2, 16'hFFFF);
    wr(INC, 16'h0, 4'b0000, 4'b0010);
    rd("wrap_inc", SEL_T2, 16'h0000);

    // Multi-select increment
    wr(LOAD, 16'h0005, 4'b0010, 4'b0000);
    wr(LOAD, 16'h00FF, 4'b0000, 4'b1000);
    wr(INC, 16'h0, 4'b0010, 4'b1000);
    rd("multi_r2", SEL_R2, 16'h0006);
    rd("multi_t4", SEL_T4, 16'h0100);
    rd("multi_r1_keep", SEL_R1, 16'hBEEF);
    rd("multi_t2_keep", SEL_T2, 16'h0000);

    // Read during write: pre-edge value until the edge
    wr(LOAD, 16'h0010, 4'b0100, 4'b0000);
    funsel = LOAD; i = 16'h0020; rsel = 4'b0100; outasel = SEL_R3; outbsel = SEL_R3; #1;
    chk("rdw_before", outa, 16'h0010);
    @(posedge clk); #1;
    rsel = '0;
    chk("rdw_after_a", outa, 16'h0020);
    chk("rdw_after_b", outb, 16'h0020);

    // No enables: funsel ignored
    funsel = CLEAR; rsel = '0; tsel = '0;
    repeat (3) @(posedge clk);
    #1;
    rd("hold_r1", SEL_R1, 16'hBEEF);
    rd("hold_r3", SEL_R3, 16'h0020);
    rd("hold_t4", SEL_T4, 16'h0100);

    // Load all, then reset mid increment run
    wr(LOAD, 16'hFFFE, 4'b1111, 4'b1111);
    wr(INC, 16'h0, 4'b1111, 4'b1111);
    rd("all_inc", SEL_T3, 16'hFFFF);
    wr(INC, 16'h0, 4'b1111, 4'b1111);
    rd("all_inc_wrap", SEL_R4, 16'h0000);
    funsel = INC; rsel = 4'b1111; tsel = 4'b1111;
    @(posedge clk); #2;
    rst = 1'b1; #1;
    rd("mid_rst_r4", SEL_R4, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0; rsel = '0; tsel = '0;
    for (int s = 0; s < 8; s++) rd("post_rst", 3'(s), 16'h0000);
    repeat (2) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
